// File: rtl/cpu64_l2_pkg.sv
// Shared L2 definitions: TileLink C opcodes, probe cap encodings and
// the probe-controller state encoding.
package cpu64_l2_pkg;

  localparam logic [2:0] PROBE_ACK      = 3'd4;
  localparam logic [2:0] PROBE_ACK_DATA = 3'd5;

  localparam logic [1:0] TO_T = 2'd0;
  localparam logic [1:0] TO_B = 2'd1;
  localparam logic [1:0] TO_N = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic logic is_probe_ack(input logic [2:0] op);
    return (op == PROBE_ACK) || (op == PROBE_ACK_DATA);
  endfunction

endpackage

// File: rtl/cpu64_l2_prio_onehot.sv
// Lowest-set-bit one-hot encoder: two's-complement isolate of the LSB.
module cpu64_l2_prio_onehot #(
  parameter int W = 4
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] gnt_o
);

  assign gnt_o = req_i & (~req_i + W'(1));

endmodule

// File: rtl/cpu64_l2_probe_ctrl.sv
// Probe fan-out / ack collection for one L2 MSHR entry: issues B-channel
// probes one core at a time and retires C-channel ProbeAck(Data).
module cpu64_l2_probe_ctrl
  import cpu64_l2_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CORES  = 4,
  parameter int ID_W   = $clog2(CORES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CORES-1:0]  start_mask_i,
  input  logic [1:0]        start_cap_i,
  output logic              busy_o,
  output logic              set_probes_o,
  output logic [CORES-1:0]  probes_mask_o,
  output logic [CORES-1:0]  b_valid_o,
  input  logic [CORES-1:0]  b_ready_i,
  output logic [ADDR_W-1:0] b_addr_o,
  output logic [1:0]        b_param_o,
  input  logic              c_valid_i,
  output logic              c_ready_o,
  input  logic [2:0]        c_opcode_i,
  input  logic [ID_W-1:0]   c_source_i,
  output logic              probe_ack_o,
  output logic [ID_W-1:0]   probe_ack_id_o,
  output logic              dirty_o,
  output logic              err_o,
  output logic              done_o
);

  logic [1:0]        state_q, state_d;
  logic [CORES-1:0]  issue_q, issue_d;
  logic [CORES-1:0]  ack_q, ack_d;
  logic              dirty_q, dirty_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cap_q;
  logic [CORES-1:0]  mask_q;
  logic              busy_q, set_probes_q, probe_ack_q, err_q, done_q;
  logic [ID_W-1:0]   probe_ack_id_q;

  logic [CORES-1:0]  b_gnt;
  logic              b_fire, c_fire, c_hit;
  logic              start_acc, ack_pulse, err_pulse;

  cpu64_l2_prio_onehot #(.W(CORES)) u_prio (
    .req_i (issue_q),
    .gnt_o (b_gnt)
  );

  assign b_valid_o = (state_q == ST_ACTIVE) ? b_gnt : '0;
  assign c_ready_o = (state_q == ST_ACTIVE);
  assign b_fire    = |(b_valid_o & b_ready_i);
  assign c_fire    = c_valid_i & c_ready_o & is_probe_ack(c_opcode_i);
  // An ack only counts once its probe has left; same-cycle B handshake is too early.
  assign c_hit     = ack_q[c_source_i] & ~issue_q[c_source_i];

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    ack_d     = ack_q;
    dirty_d   = dirty_q;
    start_acc = 1'b0;
    ack_pulse = 1'b0;
    err_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !busy_q) begin
          start_acc = 1'b1;
          issue_d   = start_mask_i;
          ack_d     = start_mask_i;
          dirty_d   = 1'b0;
          state_d   = (|start_mask_i) ? ST_ACTIVE : ST_DONE;
        end
      end
      ST_ACTIVE: begin
        if (b_fire) issue_d = issue_q & ~b_gnt;
        if (c_fire) begin
          if (c_hit) begin
            ack_d[c_source_i] = 1'b0;
            ack_pulse         = 1'b1;
            if (c_opcode_i == PROBE_ACK_DATA) dirty_d = 1'b1;
          end else begin
            err_pulse = 1'b1;
          end
        end
        if (issue_d == '0 && ack_d == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      issue_q        <= '0;
      ack_q          <= '0;
      dirty_q        <= 1'b0;
      addr_q         <= '0;
      cap_q          <= '0;
      mask_q         <= '0;
      busy_q         <= 1'b0;
      set_probes_q   <= 1'b0;
      probe_ack_q    <= 1'b0;
      probe_ack_id_q <= '0;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_q      <= issue_d;
      ack_q        <= ack_d;
      dirty_q      <= dirty_d;
      set_probes_q <= start_acc;
      probe_ack_q  <= ack_pulse;
      err_q        <= err_pulse;
      done_q       <= (state_q == ST_DONE);
      // busy covers the done pulse cycle so a new start cannot overlap it
      busy_q       <= (state_d != ST_IDLE) || (state_q == ST_DONE);
      if (start_acc) begin
        addr_q <= start_addr_i;
        cap_q  <= start_cap_i;
        mask_q <= start_mask_i;
      end
      if (ack_pulse) probe_ack_id_q <= c_source_i;
    end
  end

  assign busy_o         = busy_q;
  assign set_probes_o   = set_probes_q;
  assign probes_mask_o  = mask_q;
  assign b_addr_o       = addr_q;
  assign b_param_o      = cap_q;
  assign probe_ack_o    = probe_ack_q;
  assign probe_ack_id_o = probe_ack_id_q;
  assign dirty_o        = dirty_q;
  assign err_o          = err_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_cpu64_l2_probe_ctrl.sv
// Scoreboard bench for cpu64_l2_probe_ctrl: expected probes and acks are
// queued at stimulus time and retired by a negedge monitor.
module tb_cpu64_l2_probe_ctrl;
  localparam int AW = 64;
  localparam int NC = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] start_addr_i;
  logic [NC-1:0] start_mask_i;
  logic [1:0]    start_cap_i;
  logic          busy_o, set_probes_o;
  logic [NC-1:0] probes_mask_o, b_valid_o, b_ready_i;
  logic [AW-1:0] b_addr_o;
  logic [1:0]    b_param_o;
  logic          c_valid_i, c_ready_o;
  logic [2:0]    c_opcode_i;
  logic [IW-1:0] c_source_i;
  logic          probe_ack_o;
  logic [IW-1:0] probe_ack_id_o;
  logic          dirty_o, err_o, done_o;

  cpu64_l2_probe_ctrl #(.ADDR_W(AW), .CORES(NC), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .start_addr_i(start_addr_i), .start_mask_i(start_mask_i),
    .start_cap_i(start_cap_i), .busy_o(busy_o), .set_probes_o(set_probes_o),
    .probes_mask_o(probes_mask_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .b_addr_o(b_addr_o), .b_param_o(b_param_o), .c_valid_i(c_valid_i),
    .c_ready_o(c_ready_o), .c_opcode_i(c_opcode_i), .c_source_i(c_source_i),
    .probe_ack_o(probe_ack_o), .probe_ack_id_o(probe_ack_id_o), .dirty_o(dirty_o),
    .err_o(err_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;

  typedef struct {
    logic [NC-1:0] v;
    logic [AW-1:0] a;
    logic [1:0]    p;
  } b_exp_t;

  b_exp_t b_q[$];
  int     ack_exp[$];
  b_exp_t mon_b;
  int     mon_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (|(b_valid_o & b_ready_i)) begin
        if (b_q.size() == 0) check("b_unexpected", b_valid_o, 0);
        else begin
          mon_b = b_q.pop_front();
          check("b_valid", b_valid_o, mon_b.v);
          check("b_addr", b_addr_o, mon_b.a);
          check("b_param", b_param_o, mon_b.p);
        end
      end
      if (probe_ack_o) begin
        if (ack_exp.size() == 0) check("ack_unexpected", probe_ack_o, 0);
        else begin
          mon_id = ack_exp.pop_front();
          check("ack_id", probe_ack_id_o, mon_id);
        end
      end
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [1:0] cap, input logic [NC-1:0] m);
    for (int i = 0; i < 20 && busy_o; i++) tick();
    if (busy_o) check("start_wait", busy_o, 0);
    for (int k = 0; k < NC; k++)
      if (m[k]) begin
        b_exp_t e;
        e.v = NC'(1 << k);
        e.a = a;
        e.p = cap;
        b_q.push_back(e);
      end
    start_i = 1'b1; start_addr_i = a; start_cap_i = cap; start_mask_i = m;
    tick();
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("set_probes", set_probes_o, 1);
    check("probes_mask", probes_mask_o, m);
  endtask

  task automatic send_c(input int src, input logic [2:0] op, input bit ok);
    c_valid_i = 1'b1; c_source_i = IW'(src); c_opcode_i = op;
    if (ok) ack_exp.push_back(src);
    else if (op == 3'd4 || op == 3'd5) exp_err++;
    tick();
    c_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) begin seen = 1'b1; break; end
      tick();
    end
    check("done_seen", seen, 1);
    exp_done++;
    tick();
    check("idle_after_done", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; start_addr_i = '0; start_mask_i = '0; start_cap_i = '0;
    b_ready_i = '0; c_valid_i = 1'b0; c_opcode_i = '0; c_source_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_bvalid", b_valid_o, 0);
    check("rst_baddr", b_addr_o, 0);
    check("rst_done", done_o, 0);
    rst = 1'b0;
    tick();

    // Two sparse cores, all ready: back-to-back probes then two clean acks.
    b_ready_i = '1;
    do_start(64'h80, 2'd2, 4'b1010);
    check("t1_bv0", b_valid_o, 4'b0010);
    tick();
    check("t1_bv1", b_valid_o, 4'b1000);
    tick();
    check("t1_bv_idle", b_valid_o, 0);
    send_c(1, 3'd4, 1);
    check("t1_ack1", probe_ack_o, 1);
    send_c(3, 3'd4, 1);
    check("t1_ack3", probe_ack_o, 1);
    check("t1_no_done_yet", done_o, 0);
    tick();
    check("t1_done", done_o, 1);
    check("t1_busy_in_done", busy_o, 1);
    exp_done++;
    tick();
    check("t1_busy_clear", busy_o, 0);
    check("t1_dirty", dirty_o, 0);

    // Single core with back-pressure: valid must hold steady.
    b_ready_i = '0;
    do_start(64'h1000, 2'd0, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      check("t2_bv_hold", b_valid_o, 4'b0001);
      check("t2_addr_hold", b_addr_o, 64'h1000);
      tick();
    end
    check("t2_bv_hold6", b_valid_o, 4'b0001);
    b_ready_i = '1;
    tick();
    check("t2_bv_gone", b_valid_o, 0);
    send_c(0, 3'd5, 1);
    wait_done();
    check("t2_dirty", dirty_o, 1);

    // Empty mask: straight to done.
    do_start(64'h40, 2'd1, 4'b0000);
    check("t3_bv", b_valid_o, 0);
    tick();
    check("t3_done", done_o, 1);
    exp_done++;
    tick();
    check("t3_idle", busy_o, 0);
    check("t3_dirty_cleared", dirty_o, 0);

    // Ack from a core outside the mask.
    do_start(64'h240, 2'd1, 4'b0011);
    tick(); tick();
    send_c(2, 3'd4, 0);
    check("t4_err", err_o, 1);
    check("t4_no_ack", probe_ack_o, 0);
    check("t4_busy", busy_o, 1);
    send_c(0, 3'd4, 1);
    check("t4_err_clear", err_o, 0);
    send_c(1, 3'd5, 1);
    wait_done();
    check("t4_dirty", dirty_o, 1);

    // Full mask, acks overlap with issue; early and same-cycle acks are errors.
    b_ready_i = 4'b0011;
    do_start(64'h3c0, 2'd0, 4'b1111);
    tick(); tick();
    check("t5_stall", b_valid_o, 4'b0100);
    send_c(0, 3'd4, 1);
    send_c(3, 3'd4, 0);
    send_c(1, 3'd4, 1);
    send_c(0, 3'd1, 0);
    check("t5_ign_no_err", err_o, 0);
    check("t5_ign_no_ack", probe_ack_o, 0);
    check("t5_not_done", done_o, 0);
    check("t5_busy", busy_o, 1);
    b_ready_i = '1;
    send_c(2, 3'd4, 0);
    check("t5_same_cycle_err", err_o, 1);
    send_c(2, 3'd4, 1);
    send_c(3, 3'd5, 1);
    wait_done();
    check("t5_dirty", dirty_o, 1);

    // Reset with two acks outstanding, then a fresh transaction.
    do_start(64'h500, 2'd2, 4'b0011);
    tick(); tick();
    check("t6_outstanding", busy_o, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_bvalid", b_valid_o, 0);
    check("t6_rst_baddr", b_addr_o, 0);
    check("t6_rst_bparam", b_param_o, 0);
    check("t6_rst_mask", probes_mask_o, 0);
    check("t6_rst_cready", c_ready_o, 0);
    tick();
    rst = 1'b0;
    tick();
    do_start(64'h600, 2'd1, 4'b0100);
    check("t6_fresh_bv", b_valid_o, 4'b0100);
    tick();
    send_c(2, 3'd4, 1);
    wait_done();
    check("t6_dirty", dirty_o, 0);

    repeat (2) tick();
    check("done_count", done_cnt, exp_done);
    check("err_count", err_cnt, exp_err);
    check("b_queue_empty", b_q.size(), 0);
    check("ack_queue_empty", ack_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu64_l2_probe_ctrl.md
# cpu64_l2_probe_ctrl

Probe fan-out/collection stage for one L2 MSHR entry. On a start from the L2 FSM it drives TileLink B-channel Probes to each core in a sharer mask and absorbs C-channel ProbeAck/ProbeAckData. It feeds the MSHR's `set_probes`/`probe_ack` inputs so the MSHR's pending-probe mask tracks outstanding acks, and it signals completion.

## Interface
- `ADDR_W`, 64: address width
- `CORES`, 4: number of L1 clients (power of 2, ≥2)
- `ID_W`, `$clog2(CORES)`: core index width (derived)
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start_i` in 1: start request; accepted only when `busy_o`=0
- `start_addr_i` in ADDR_W: line address to probe
- `start_mask_i` in CORES: cores to probe
- `start_cap_i` in 2: cap param (0=toT, 1=toB, 2=toN)
- `busy_o` out 1: not IDLE
- `set_probes_o` out 1: one-cycle pulse → MSHR `set_probes`
- `probes_mask_o` out CORES: mask latched at start → MSHR `probes_mask`
- `b_valid_o` out CORES: per-core Probe valid, at most one bit set
- `b_ready_i` in CORES: per-core Probe ready
- `b_addr_o` out ADDR_W, `b_param_o` out 2: Probe address/cap, shared by all cores
- `c_valid_i` in 1, `c_ready_o` out 1: C-channel handshake
- `c_opcode_i` in 3: 4=ProbeAck, 5=ProbeAckData; others ignored
- `c_source_i` in ID_W: responding core
- `probe_ack_o` out 1, `probe_ack_id_o` out ID_W: → MSHR `probe_ack`/`probe_ack_id`
- `dirty_o` out 1: a ProbeAckData was received this transaction
- `err_o` out 1: one-cycle pulse on unexpected ack
- `done_o` out 1: one-cycle pulse, all acks collected

## Operation
- Registers: `issue_q` (probes not yet sent), `ack_q` (acks outstanding), addr/cap, `dirty_q`, state.
- FSM: IDLE → ACTIVE → DONE → IDLE.
- IDLE: `start_i` latches addr, cap, `issue_q=ack_q=start_mask_i`, clears `dirty_q`, goes to ACTIVE; if mask=0 goes to DONE. `set_probes_o` pulses either way.
- ACTIVE: `b_valid_o` = one-hot of lowest set bit of `issue_q`. On `b_valid&b_ready` for that core, clear its `issue_q` bit; the next core's valid can rise the following cycle. `c_ready_o`=1.
- C accept (`c_valid_i&c_ready_o`, opcode 4/5): if `ack_q[src]`=1 and `issue_q[src]`=0, clear `ack_q[src]`, pulse `probe_ack_o` with id=src next cycle, and for opcode 5 set `dirty_q`. Otherwise (not outstanding, or probe not yet issued) pulse `err_o` only; state unchanged. Opcodes other than 4/5 are accepted and dropped without error.
- Leave ACTIVE for DONE when `issue_q` and `ack_q` (after this cycle's updates) are both 0.
- DONE: `done_o`=1 for one cycle, `c_ready_o`=0, then IDLE. `dirty_o` holds `dirty_q` until the next start.
- B and C handshakes in the same cycle are independent. An ack for core k cannot complete while core k's probe is in the same B handshake cycle; that ack is an error.

## Timing
- All outputs are registered except `b_valid_o` and `c_ready_o`, which decode from state and `issue_q`.
- Reset: state IDLE and all outputs 0, including `b_addr_o`/`b_param_o`.
- Start accepted in cycle N: `busy_o`, `set_probes_o`, and first `b_valid_o` are visible in N+1.
- C handshake in cycle M: `probe_ack_o` in M+1. If it was the last ack, `done_o` in M+2 and `busy_o`=0 in M+3.
- `b_valid_o` is held with stable addr/param until ready; it is never withdrawn.
- `rst` mid-transaction aborts immediately to IDLE. Nothing is reported to the MSHR; the MSHR is reset by the same `rst`.

## Structure
- Shared `cpu64_l2_pkg`: TL C opcodes (PROBE_ACK=4, PROBE_ACK_DATA=5), cap encodings (TO_T/TO_B/TO_N), FSM state enum.
- Sub-module `cpu64_l2_prio_onehot`: parameterised lowest-set-bit one-hot encoder, used for `b_valid_o`.

## Test plan
- Mask 4'b1010, cap toN, addr 0x80, all ready=1: b_valid 0010 then 1000 on consecutive cycles, both with addr 0x80 and param 2. Acks from cores 1 and 3 give `probe_ack_o` id 1 then id 3, `done_o` once, `dirty_o`=0.
- Mask 4'b0001, core 0 `b_ready` low for 5 cycles: `b_valid_o` stays 0001 stable for 6 cycles. A ProbeAckData afterwards gives `dirty_o`=1 and `done_o`.
- Mask 0: `set_probes_o` with mask 0, `done_o` 2 cycles after start, no `b_valid_o`.
- Ack from core 2 with mask 4'b0011: `err_o` pulse, no `probe_ack_o`, `ack_q` unchanged, still busy.
- Mask 4'b1111 with acks for cores 0 and 1 arriving while cores 2 and 3 are still issuing: acks are counted, `done_o` only after all four.
- `rst` asserted while 2 acks are outstanding: all outputs 0 asynchronously. A new start afterwards behaves like a fresh transaction.
